token_parser: RTL
=================

# token_parser

Second-generation Forth front-end parser. Accepts a handshaked character stream from the tokenizer, accumulates delimiter-separated words in an internal buffer, converts each word sequentially (one character per cycle) into one of:
- a decimal literal
- a hex literal
- a built-in dictionary opcode

It then presents the result as a single token to the CPU over a valid/ready handshake, with explicit error and end-of-line signalling.

## Interface
Parameters:
- WIDTH, 32, maximum word length in characters (buffer depth)
- DATA, 32, literal/data width in bits; multiple of 4
- OPCODE, 16, opcode width in bits

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  global enable; low freezes all state and outputs
- i_data  in  8  character
- i_valid  in  1  character available
- i_wc  in  1  character is whitespace delimiter (qualifies i_data)
- i_eol  in  1  character is end-of-line delimiter (qualifies i_data)
- o_ready  out  1  parser accepts a character this cycle
- o_opcode  out  OPCODE  token opcode
- o_data  out  DATA  token operand
- o_err  out  1  token is an error token
- o_eol  out  1  token terminated by end-of-line
- o_valid  out  1  token available
- i_ready  in  1  CPU consumes token
- o_state  out  2  current state (debug)

## Operation
- Opcodes:
  - NOP=0, PUSH=1, DROP=2, ADD=3, SUB=4, DUP=5, SWAP=6, EMIT=7.
  - Dictionary words, case-sensitive: "DROP", "+", "-", "DUP", "SWAP", ".".
- State COLLECT (0):
  - o_ready=1.
  - A character is accepted when i_valid & o_ready & i_en.
  - A non-delimiter character is written to buf[len], then len increments.
  - A delimiter with len=0 is ignored (no token) if it is i_wc. If it is i_eol, it emits a NOP token with o_eol=1.
  - A delimiter with len>0 latches eol_flag=i_eol and moves to CONVERT with idx=0.
  - A non-delimiter character arriving when len==WIDTH sets the overflow flag and moves to DRAIN.
- State DRAIN (1):
  - o_ready=1.
  - Non-delimiter characters are discarded.
  - The next delimiter emits an error token and latches o_eol=i_eol.
- State CONVERT (2):
  - o_ready=0.
  - Processes buf[idx] once per cycle, idx=0..len-1, updating three trackers in parallel.
  - Decimal tracker: acc=acc*10+digit. Any non-digit, or a result ≥2^DATA, sets dec_bad.
  - Hex tracker: requires buf[0]='0' and buf[1] in {'x','X'}, followed by 1..DATA/4 digits from 0-9/a-f/A-F. acc=(acc<<4)|nibble. Otherwise hex_bad is set.
  - Dictionary compare: a running per-entry match vector; an entry fails on any character mismatch or a length mismatch.
  - After the last character, the state moves to OUTPUT.
  - Priority: decimal > hex > dictionary. A decimal or hex match gives opcode=PUSH with data=value. A dictionary match gives opcode=entry and data=0. No match gives o_err=1, opcode=0, data=0.
- State OUTPUT (3):
  - o_valid=1.
  - Outputs are held stable until i_valid... more precisely, until i_ready is sampled high.
  - On the handshake: clear buf/len/trackers and return to COLLECT.
- Reset:
  - state=COLLECT, o_ready=0 during reset then 1.
  - o_valid=0, o_opcode=0, o_data=0, o_err=0, o_eol=0, len=0.
  - Buffer cleared.
  - Reset mid-word or mid-token discards everything.

## Timing
- One character is accepted per cycle in COLLECT/DRAIN.
- Delimiter accepted at edge E0 → CONVERT on edges E1..E_len → o_valid rises after edge E_len.
  - Latency is len cycles from the delimiter edge; a length-1 word gives o_valid after E1.
- Empty-EOL NOP and DRAIN error tokens skip CONVERT: o_valid rises after E0.
- The token is consumed on the edge where o_valid & i_ready & i_en. o_ready is 1 in the following cycle.
- No input is accepted while a token is pending (no bypass).
- i_en low: no state, counter, or output changes; handshakes do not complete.

## Configuration
- TOKEN_PARSER_NEG_EN defined:
  - A leading '-' followed by ≥1 digit is a valid decimal. The value is two's-complement negated at OUTPUT.
  - Magnitude limit is 2^(DATA-1) for negatives and 2^DATA-1 for positives.
  - A lone "-" still matches SUB.
- Undefined: '-' is only the SUB dictionary word; "-5" yields an error token.

## Test plan
- "123 " → one token: PUSH, data=123, err=0, eol=0. o_valid rises 3 cycles after the space is accepted.
- "0x1F\n" then "DUP " → PUSH data=0x1F eol=1, then opcode=5 data=0 eol=0. Hold i_ready low 4 cycles on the first token: outputs stable, o_ready=0.
- 33 'A' characters then ' ' with WIDTH=32 → single error token (err=1) emitted the cycle after the space. The following "+ " yields opcode=3.
- "4294967296 " with DATA=32 → error token. "4294967295 " → PUSH 0xFFFFFFFF. "0x123456789 " → error.
- "  \n" → only a NOP token with eol=1. Assert i_rst mid-CONVERT of "SWAP " → o_valid=0, o_ready=1 after release, no token emitted.
- With TOKEN_PARSER_NEG_EN: "-5 " → PUSH 0xFFFFFFFB, and "- " → SUB. Without it: "-5 " → err=1.

Source files
------------

// File: rtl/token_parser.sv
// Forth word parser: turns a delimited character stream into literal/opcode tokens.
// Define TOKEN_PARSER_NEG_EN to accept negative decimal literals ("-5").
module token_parser #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DATA   = 32,
    parameter int unsigned OPCODE = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    input  logic              i_wc,
    input  logic              i_eol,
    output logic              o_ready,
    output logic [OPCODE-1:0] o_opcode,
    output logic [DATA-1:0]   o_data,
    output logic              o_err,
    output logic              o_eol,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        o_state
);
    localparam int unsigned LW    = $clog2(WIDTH + 1);
    localparam int unsigned IW    = $clog2(WIDTH);
    localparam int unsigned DW    = DATA + 4;
    localparam int unsigned NDICT = 6;
    // Entry e maps to opcode e+2; strings are right-aligned in 32 bits.
    localparam logic [31:0] DictStr [NDICT] = '{"DROP", "+", "-", "DUP", "SWAP", "."};
    localparam int unsigned DictLen [NDICT] = '{4, 1, 1, 3, 4, 1};

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StDrain   = 2'd1,
        StConvert = 2'd2,
        StOutput  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        word_q [WIDTH];
    logic [7:0]        word_d [WIDTH];
    logic [LW-1:0]     len_q, len_d, idx_q, idx_d;
    logic [DATA-1:0]   dec_q, dec_d, hex_q, hex_d;
    logic              dec_bad_q, dec_bad_d, hex_bad_q, hex_bad_d, neg_q, neg_d;
    logic [NDICT-1:0]  match_q, match_d;
    logic [OPCODE-1:0] opcode_q, opcode_d;
    logic [DATA-1:0]   data_q, data_d;
    logic              err_q, err_d, eol_q, eol_d, valid_q, valid_d;

    logic [7:0]        ch, ec;
    logic [3:0]        nib;
    logic              is_dig, is_hex, last, delim;
    logic [DW-1:0]     dec_wide;
    logic [DATA-1:0]   dec_step, hex_step;
    logic              dec_bad_step, hex_bad_step, neg_step, dec_ok, hex_ok;
    logic [NDICT-1:0]  match_step, match_fin;
    logic [OPCODE-1:0] dict_op;

    assign delim = i_wc | i_eol;

    // One character step of the three trackers, plus the final verdict on the last character.
    always_comb begin
        ch     = word_q[idx_q[IW-1:0]];
        is_dig = (ch >= "0") && (ch <= "9");
        is_hex = is_dig;
        nib    = ch[3:0];
        if ((ch >= "a" && ch <= "f") || (ch >= "A" && ch <= "F")) begin
            is_hex = 1'b1;
            nib    = ch[3:0] + 4'd9;
        end
        last = (idx_q == len_q - LW'(1));

        dec_wide     = {4'b0, dec_q} * DW'(10) + DW'(ch[3:0]);
        dec_step     = dec_wide[DATA-1:0];
        dec_bad_step = dec_bad_q | ~is_dig | (|dec_wide[DW-1:DATA]);
        neg_step     = neg_q;
`ifdef TOKEN_PARSER_NEG_EN
        if (idx_q == '0 && ch == "-") begin
            dec_step     = dec_q;
            dec_bad_step = dec_bad_q;
            neg_step     = 1'b1;
        end
`endif
        dec_ok = ~dec_bad_step;
`ifdef TOKEN_PARSER_NEG_EN
        if (neg_step && (len_q == LW'(1) || dec_step > {1'b1, {(DATA-1){1'b0}}})) begin
            dec_ok = 1'b0;
        end
`endif

        hex_step     = {hex_q[DATA-5:0], nib};
        hex_bad_step = hex_bad_q;
        if (idx_q == LW'(0)) begin
            hex_step     = '0;
            hex_bad_step = hex_bad_q | (ch != "0");
        end else if (idx_q == LW'(1)) begin
            hex_step     = '0;
            hex_bad_step = hex_bad_q | ((ch != "x") && (ch != "X"));
        end else begin
            hex_bad_step = hex_bad_q | ~is_hex;
        end
        hex_ok = ~hex_bad_step && (int'(len_q) >= 3) && (int'(len_q) <= DATA / 4 + 2);

        match_step = match_q;
        match_fin  = '0;
        dict_op    = '0;
        ec         = '0;
        for (int e = 0; e < NDICT; e++) begin
            ec = 8'h00;
            if (int'(idx_q) < DictLen[e]) begin
                ec = 8'(DictStr[e] >> (8 * (DictLen[e] - 1 - int'(idx_q))));
            end
            match_step[e] = match_q[e] & (ch == ec);
            match_fin[e]  = match_step[e] & (int'(len_q) == DictLen[e]);
        end
        for (int e = NDICT - 1; e >= 0; e--) begin
            if (match_fin[e]) dict_op = OPCODE'(e + 2);
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        len_d     = len_q;
        idx_d     = idx_q;
        dec_d     = dec_q;
        dec_bad_d = dec_bad_q;
        neg_d     = neg_q;
        hex_d     = hex_q;
        hex_bad_d = hex_bad_q;
        match_d   = match_q;
        opcode_d  = opcode_q;
        data_d    = data_q;
        err_d     = err_q;
        eol_d     = eol_q;
        valid_d   = valid_q;
        if (i_en) begin
            unique case (state_q)
                StCollect: begin
                    if (i_valid) begin
                        if (delim) begin
                            if (len_q != '0) begin
                                eol_d   = i_eol;
                                idx_d   = '0;
                                state_d = StConvert;
                            end else if (i_eol) begin
                                eol_d   = 1'b1;
                                valid_d = 1'b1;
                                state_d = StOutput;
                            end
                        end else if (len_q == LW'(WIDTH)) begin
                            state_d = StDrain;
                        end else begin
                            word_d[len_q[IW-1:0]] = i_data;
                            len_d = len_q + LW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (i_valid && delim) begin
                        err_d   = 1'b1;
                        eol_d   = i_eol;
                        valid_d = 1'b1;
                        state_d = StOutput;
                    end
                end
                StConvert: begin
                    idx_d     = idx_q + LW'(1);
                    dec_d     = dec_step;
                    dec_bad_d = dec_bad_step;
                    neg_d     = neg_step;
                    hex_d     = hex_step;
                    hex_bad_d = hex_bad_step;
                    match_d   = match_step;
                    if (last) begin
                        valid_d = 1'b1;
                        state_d = StOutput;
                        if (dec_ok) begin
                            opcode_d = OPCODE'(1);
                            data_d   = neg_step ? (~dec_step + DATA'(1)) : dec_step;
                        end else if (hex_ok) begin
                            opcode_d = OPCODE'(1);
                            data_d   = hex_step;
                        end else if (|match_fin) begin
                            opcode_d = dict_op;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StOutput: begin
                    if (i_ready) begin
                        for (int i = 0; i < WIDTH; i++) word_d[i] = '0;
                        len_d     = '0;
                        idx_d     = '0;
                        dec_d     = '0;
                        dec_bad_d = 1'b0;
                        neg_d     = 1'b0;
                        hex_d     = '0;
                        hex_bad_d = 1'b0;
                        match_d   = '1;
                        opcode_d  = '0;
                        data_d    = '0;
                        err_d     = 1'b0;
                        eol_d     = 1'b0;
                        valid_d   = 1'b0;
                        state_d   = StCollect;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StCollect;
            for (int i = 0; i < WIDTH; i++) word_q[i] <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            dec_q     <= '0;
            dec_bad_q <= 1'b0;
            neg_q     <= 1'b0;
            hex_q     <= '0;
            hex_bad_q <= 1'b0;
            match_q   <= '1;
            opcode_q  <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            eol_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            dec_q     <= dec_d;
            dec_bad_q <= dec_bad_d;
            neg_q     <= neg_d;
            hex_q     <= hex_d;
            hex_bad_q <= hex_bad_d;
            match_q   <= match_d;
            opcode_q  <= opcode_d;
            data_q    <= data_d;
            err_q     <= err_d;
            eol_q     <= eol_d;
            valid_q   <= valid_d;
        end
    end

    assign o_ready  = ~i_rst & ~state_q[1];
    assign o_opcode = opcode_q;
    assign o_data   = data_q;
    assign o_err    = err_q;
    assign o_eol    = eol_q;
    assign o_valid  = valid_q;
    assign o_state  = state_q;

endmodule
